// File: rtl/reg2ip_snapshot_bank.sv
// Register-to-IP write bank with per-channel ack and a handshaked, coherent
// readback snapshot of all registers, a write-event counter and a status word.
module reg2ip_snapshot_bank #(
    parameter int unsigned           NUM_REGS    = 3,
    parameter int unsigned           REG_WIDTH   = 32,
    parameter logic [REG_WIDTH-1:0]  RESET_VAL   = '0,
    parameter int unsigned           SNAP_PERIOD = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_REGS*REG_WIDTH-1:0]       reg2ip_data_i,
    input  logic [NUM_REGS-1:0]                 reg2ip_en_i,
    output logic [NUM_REGS-1:0]                 reg2ip_ack_o,
    input  logic                                snap_req_i,
    output logic [(NUM_REGS+2)*REG_WIDTH-1:0]   ip2reg_data_o,
    output logic                                ip2reg_valid_o,
    input  logic                                ip2reg_ready_i
);

    localparam int unsigned SNAP_W = (NUM_REGS + 2) * REG_WIDTH;
    localparam int unsigned CNT_W  = REG_WIDTH + 4;
    localparam logic [REG_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT_QUIET, VALID} state_e;

    state_e               state_q, state_d;
    logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
    logic [REG_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [7:0]           seq_q;
    logic                 pending_q, pending_d;
    logic                 pend_auto_q, pend_auto_d;
    logic                 overrun_q, overrun_d;
    logic                 new_ovr, capture, cap_auto;
    logic [NUM_REGS-1:0]  ack_q;
    logic [SNAP_W-1:0]    data_q, snap_w;
    logic                 valid_q;
    logic                 auto_trig, trigger, t_auto_only, quiet, merged_auto;
    logic [CNT_W-1:0]     pop_w, cnt_sum;
    logic [31:0]          status_w;

    // Free-running period timer; auto trigger fires in its last cycle
    if (SNAP_PERIOD > 0) begin : g_timer
        logic [31:0] timer_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                timer_q <= '0;
            end else if (timer_q == 32'(SNAP_PERIOD - 1)) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 32'd1;
            end
        end
        assign auto_trig = (timer_q == 32'(SNAP_PERIOD - 1));
    end else begin : g_no_timer
        assign auto_trig = 1'b0;
    end

    assign trigger     = snap_req_i | auto_trig;
    assign t_auto_only = auto_trig & ~snap_req_i;
    assign quiet       = (reg2ip_en_i == '0);
    // A pending snapshot stays "auto only" until a request joins it
    assign merged_auto = pending_q ? (pend_auto_q & (~trigger | t_auto_only)) : t_auto_only;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pend_auto_d = pend_auto_q;
        new_ovr     = 1'b0;
        capture     = 1'b0;
        cap_auto    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger || pending_q) begin
                    if (quiet) begin
                        capture   = 1'b1;
                        cap_auto  = merged_auto;
                        pending_d = 1'b0;
                        state_d   = VALID;
                    end else begin
                        pending_d   = 1'b1;
                        pend_auto_d = merged_auto;
                        new_ovr     = trigger & pending_q;
                        state_d     = WAIT_QUIET;
                    end
                end
            end
            WAIT_QUIET: begin
                if (quiet) begin
                    // The held request is consumed; a fresh trigger becomes the next one
                    capture     = 1'b1;
                    cap_auto    = pend_auto_q;
                    pending_d   = trigger;
                    pend_auto_d = t_auto_only;
                    state_d     = VALID;
                end else if (trigger) begin
                    pending_d   = 1'b1;
                    pend_auto_d = merged_auto;
                    new_ovr     = pending_q;
                end
            end
            VALID: begin
                if (trigger) begin
                    pending_d   = 1'b1;
                    pend_auto_d = merged_auto;
                    new_ovr     = pending_q;
                end
                if (ip2reg_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        overrun_d = (overrun_q & ~capture) | new_ovr;
    end

    // Saturating write-event counter and snapshot assembly
    always_comb begin
        pop_w = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            pop_w = pop_w + CNT_W'(reg2ip_en_i[i]);
        end
        cnt_sum  = CNT_W'(wr_cnt_q) + pop_w;
        wr_cnt_d = (cnt_sum > CNT_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[REG_WIDTH-1:0];

        status_w = {17'b0, seq_q, 5'b0, cap_auto, overrun_q};
        snap_w   = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            snap_w[(int'(NUM_REGS) + 2 - i)*int'(REG_WIDTH) - 1 -: REG_WIDTH] = regs_q[i];
        end
        snap_w[2*REG_WIDTH-1 -: REG_WIDTH] = wr_cnt_q;
        snap_w[REG_WIDTH-1:0]              = REG_WIDTH'(status_w);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wr_cnt_q    <= '0;
            seq_q       <= '0;
            pending_q   <= 1'b0;
            pend_auto_q <= 1'b0;
            overrun_q   <= 1'b0;
            ack_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (reg2ip_en_i[i]) begin
                    regs_q[i] <= reg2ip_data_i[(int'(NUM_REGS) - i)*int'(REG_WIDTH) - 1 -: REG_WIDTH];
                end
            end
            wr_cnt_q    <= wr_cnt_d;
            pending_q   <= pending_d;
            pend_auto_q <= pend_auto_d;
            overrun_q   <= overrun_d;
            ack_q       <= reg2ip_en_i;
            valid_q     <= (state_d == VALID);
            if (capture) begin
                data_q <= snap_w;
                seq_q  <= seq_q + 8'd1;
            end
        end
    end

    assign reg2ip_ack_o   = ack_q;
    assign ip2reg_data_o  = data_q;
    assign ip2reg_valid_o = valid_q;

endmodule

// File: tb/tb_reg2ip_snapshot_bank.sv
// Scoreboard bench for reg2ip_snapshot_bank: manual, auto-triggered and
// narrow saturating instances.
module tb_reg2ip_snapshot_bank;

    localparam int unsigned N  = 3;
    localparam int unsigned W  = 32;
    localparam int unsigned SW = (N + 2) * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, req, ready, valid;
    logic [N*W-1:0]  wdata;
    logic [N-1:0]    en, ack;
    logic [SW-1:0]   rdata;

    logic            rst_na, req_a, ready_a, valid_a;
    logic [N*W-1:0]  wdata_a;
    logic [N-1:0]    en_a, ack_a;
    logic [SW-1:0]   rdata_a;

    logic            req_s, ready_s, valid_s;
    logic [N*8-1:0]  wdata_s;
    logic [N-1:0]    en_s, ack_s;
    logic [5*8-1:0]  rdata_s;

    reg2ip_snapshot_bank #(.NUM_REGS(N), .REG_WIDTH(W), .RESET_VAL(32'h0), .SNAP_PERIOD(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .reg2ip_data_i(wdata), .reg2ip_en_i(en),
        .reg2ip_ack_o(ack), .snap_req_i(req), .ip2reg_data_o(rdata),
        .ip2reg_valid_o(valid), .ip2reg_ready_i(ready));

    reg2ip_snapshot_bank #(.NUM_REGS(N), .REG_WIDTH(W), .RESET_VAL(32'h5A5A_0000), .SNAP_PERIOD(8)) dut_auto (
        .clk_i(clk), .rst_ni(rst_na), .reg2ip_data_i(wdata_a), .reg2ip_en_i(en_a),
        .reg2ip_ack_o(ack_a), .snap_req_i(req_a), .ip2reg_data_o(rdata_a),
        .ip2reg_valid_o(valid_a), .ip2reg_ready_i(ready_a));

    reg2ip_snapshot_bank #(.NUM_REGS(N), .REG_WIDTH(8), .SNAP_PERIOD(0)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .reg2ip_data_i(wdata_s), .reg2ip_en_i(en_s),
        .reg2ip_ack_o(ack_s), .snap_req_i(req_s), .ip2reg_data_o(rdata_s),
        .ip2reg_valid_o(valid_s), .ip2reg_ready_i(ready_s));

    int unsigned     n_vec = 0;
    int unsigned     n_err = 0;
    int              cyc   = 0;
    int              last_a = -1;
    logic [SW-1:0]   sb[$];
    logic [SW-1:0]   sb_a[$];
    logic [W-1:0]    m_reg [N];
    logic [W-1:0]    m_cnt;
    logic [7:0]      m_seq;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] st(input bit ovr, input bit aut, input logic [7:0] seq);
        return {17'b0, seq, 5'b0, aut, ovr};
    endfunction

    function automatic logic [SW-1:0] exp_snap(input logic [W-1:0] status);
        return {m_reg[0], m_reg[1], m_reg[2], m_cnt, status};
    endfunction

    // Snapshot monitors: held data is compared every valid cycle, popped on handshake
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", SW'(1), SW'(0));
            end else begin
                chk("snapshot", rdata, sb[0]);
                if (ready) void'(sb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (valid_a) begin
            if (sb_a.size() == 0) begin
                chk("unexpected_auto", SW'(1), SW'(0));
            end else begin
                chk("auto_snapshot", rdata_a, sb_a.pop_front());
                if (last_a >= 0) chk("auto_period", SW'(cyc - last_a), SW'(8));
                last_a = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = '0; req = 1'b0; ready = 1'b1; wdata = '0;
        en_s = '0; req_s = 1'b0; wdata_s = '0;
        sb.delete();
        for (int i = 0; i < int'(N); i++) m_reg[i] = '0;
        m_cnt = '0;
        m_seq = '0;
        #1;
        chk("rst_ack", SW'(ack), SW'(0));
        chk("rst_valid", SW'(valid), SW'(0));
        chk("rst_data", rdata, SW'(0));
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [N-1:0] e, input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
        logic [W-1:0] d [N];
        d[0] = d0; d[1] = d1; d[2] = d2;
        en = e;
        wdata = {d0, d1, d2};
        for (int i = 0; i < int'(N); i++) if (e[i]) m_reg[i] = d[i];
        m_cnt = m_cnt + W'($countones(e));
        step();
        chk("ack", SW'(ack), SW'(e));
    endtask

    task automatic snap(input bit ovr);
        req = 1'b1;
        sb.push_back(exp_snap(st(ovr, 1'b0, m_seq)));
        m_seq++;
        step();
        req = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        chk(tag, SW'(sb.size()), SW'(0));
    endtask

    initial begin
        rst_na = 1'b0; req_a = 1'b0; ready_a = 1'b1; wdata_a = '0; en_a = '0;
        ready_s = 1'b1;

        // Three-channel write in one cycle, then a requested snapshot
        do_reset();
        wr(3'b111, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
        en = '0;
        step();
        chk("ack_one_cycle", SW'(ack), SW'(0));
        snap(1'b0);
        chk("t1_valid_next", SW'(valid), SW'(1));
        drain("t1_drain");

        // Back-to-back strobes on channel 1
        do_reset();
        wr(3'b010, 32'h0, 32'h10, 32'h0);
        wr(3'b010, 32'h0, 32'h11, 32'h0);
        en = '0;
        step();
        chk("t2_ack_low", SW'(ack), SW'(0));
        snap(1'b0);
        drain("t2_drain");

        // Request during writes waits for the first quiet edge
        do_reset();
        req = 1'b1;
        wr(3'b001, 32'h30, 32'h0, 32'h0);
        req = 1'b0;
        chk("t3_no_cap0", SW'(valid), SW'(0));
        wr(3'b001, 32'h31, 32'h0, 32'h0);
        chk("t3_no_cap1", SW'(valid), SW'(0));
        wr(3'b001, 32'h32, 32'h0, 32'h0);
        chk("t3_no_cap2", SW'(valid), SW'(0));
        en = '0;
        sb.push_back(exp_snap(st(1'b0, 1'b0, m_seq)));
        m_seq++;
        step();
        chk("t3_valid", SW'(valid), SW'(1));
        drain("t3_drain");

        // Held request under back-pressure produces overrun in the next snapshot
        do_reset();
        ready = 1'b0;
        req = 1'b1;
        sb.push_back(exp_snap(st(1'b0, 1'b0, m_seq)));
        m_seq++;
        repeat (5) step();
        chk("t4_held", SW'(valid), SW'(1));
        req = 1'b0;
        ready = 1'b1;
        sb.push_back(exp_snap(st(1'b1, 1'b0, m_seq)));
        m_seq++;
        step();
        chk("t4_gap", SW'(valid), SW'(0));
        drain("t4_drain_ovr");
        snap(1'b0);
        drain("t4_drain_clr");

        // Periodic auto-trigger
        for (int k = 0; k < 3; k++) begin
            sb_a.push_back({32'h5A5A_0000, 32'h5A5A_0000, 32'h5A5A_0000, 32'h0, st(1'b0, 1'b1, 8'(k))});
        end
        rst_na = 1'b1;
        for (int i = 0; i < 40 && sb_a.size() != 0; i++) step();
        chk("auto_drain", SW'(sb_a.size()), SW'(0));
        rst_na = 1'b0;

        // Reset while a snapshot is held
        do_reset();
        wr(3'b111, 32'h1, 32'h2, 32'h3);
        en = '0;
        ready = 1'b0;
        snap(1'b0);
        wr(3'b111, 32'h4, 32'h5, 32'h6);
        chk("t6_valid_hi", SW'(valid), SW'(1));
        do_reset();
        snap(1'b0);
        drain("t6_drain");

        // Narrow instance: counter saturation and truncated status
        do_reset();
        en_s = 3'b111;
        wdata_s = {8'h11, 8'h22, 8'h33};
        repeat (90) step();
        en_s = '0;
        step();
        req_s = 1'b1;
        step();
        req_s = 1'b0;
        chk("sat_valid", SW'(valid_s), SW'(1));
        chk("sat_snap0", SW'(rdata_s), SW'({8'h11, 8'h22, 8'h33, 8'hFF, 8'h00}));
        step();
        req_s = 1'b1;
        step();
        req_s = 1'b0;
        chk("sat_snap1", SW'(rdata_s), SW'({8'h11, 8'h22, 8'h33, 8'hFF, 8'h80}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
